id_ex_stage: RTL and testbench

// - ID/EX pipeline register of the 16-bit, 8-register pipelined MIPS core.
// - Captures the two register file read ports, the immediate and the decoded control for one instruction.
// - Bypasses a same-cycle WB write, so EX never sees a stale operand.
// - Detects load-use hazards: inserts a bubble and asserts a stall to the IF/ID stage.

---
 rtl/mips_pkg.sv | 27 ++
 rtl/wb_bypass_mux.sv | 34 +++
 rtl/id_ex_stage.sv | 139 +++++++++++++
 tb/tb_id_ex_stage.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared widths, ALU opcodes and the control
// bundle of the 16-bit pipelined MIPS core.
package mips_pkg;

  localparam int DATA_W  = 16;
  localparam int REG_AW  = 3;
  localparam int ALUOP_W = 3;

  localparam logic [ALUOP_W-1:0] ALU_NOP = 3'd0;
  localparam logic [ALUOP_W-1:0] ALU_ADD = 3'd1;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 3'd2;
  localparam logic [ALUOP_W-1:0] ALU_AND = 3'd3;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 3'd4;
  localparam logic [ALUOP_W-1:0] ALU_SLT = 3'd5;

  typedef struct packed {
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/wb_bypass_mux.sv
// Operand select: r0 reads zero, a same-cycle
// WB write to the source register wins over the regfile.
module wb_bypass_mux
  import mips_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = REG_AW
) (
  input  logic [AW-1:0] src_reg,
  input  logic [DW-1:0] rd_data,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_reg,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] operand
);

  logic src_zero;
  logic wb_hit;

  assign src_zero = (src_reg == '0);
  assign wb_hit   = wb_we && (wb_reg != '0)
                 && (wb_reg == src_reg);

  // r0 first, then the WB bypass, else the regfile
  always_comb begin
    operand = rd_data;
    unique case (1'b1)
      src_zero: operand = '0;
      wb_hit:   operand = wb_data;
      default:  operand = rd_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB bypass,
// load-use stall detection and a stall counter.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W  = mips_pkg::DATA_W,
  parameter int REG_AW  = mips_pkg::REG_AW,
  parameter int ALUOP_W = mips_pkg::ALUOP_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic               id_RegWrite,
  input  logic               id_MemRead,
  input  logic               id_MemWrite,
  input  logic               id_MemtoReg,
  input  logic               id_ALUSrc,
  input  logic [ALUOP_W-1:0] id_ALUOp,
  input  logic [DATA_W-1:0]  regfile_read_data_1,
  input  logic [DATA_W-1:0]  regfile_read_data_2,
  input  logic               wb_RegWrite,
  input  logic [REG_AW-1:0]  wb_write_reg,
  input  logic [DATA_W-1:0]  wb_write_data,
  input  logic               flush,
  output logic               stall,
  output logic               ex_valid,
  output logic [REG_AW-1:0]  ex_rs,
  output logic [REG_AW-1:0]  ex_rt,
  output logic [REG_AW-1:0]  ex_rd,
  output logic [DATA_W-1:0]  ex_a,
  output logic [DATA_W-1:0]  ex_b,
  output logic [DATA_W-1:0]  ex_imm,
  output logic               ex_RegWrite,
  output logic               ex_MemRead,
  output logic               ex_MemWrite,
  output logic               ex_MemtoReg,
  output logic               ex_ALUSrc,
  output logic [ALUOP_W-1:0] ex_ALUOp,
  output logic [15:0]        stall_count
);

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  ctrl_t             id_ctrl;
  ctrl_t             ex_ctrl;
  logic              stall_hit;
  logic              bubble;

  wb_bypass_mux #(
    .DW (DATA_W),
    .AW (REG_AW)
  ) u_mux_a (
    .src_reg (id_rs),
    .rd_data (regfile_read_data_1),
    .wb_we   (wb_RegWrite),
    .wb_reg  (wb_write_reg),
    .wb_data (wb_write_data),
    .operand (op_a)
  );

  wb_bypass_mux #(
    .DW (DATA_W),
    .AW (REG_AW)
  ) u_mux_b (
    .src_reg (id_rt),
    .rd_data (regfile_read_data_2),
    .wb_we   (wb_RegWrite),
    .wb_reg  (wb_write_reg),
    .wb_data (wb_write_data),
    .operand (op_b)
  );

  // Gather decoded control; an empty ID slot carries none
  always_comb begin
    id_ctrl = CTRL_BUBBLE;
    if (id_valid) begin
      id_ctrl.reg_write  = id_RegWrite;
      id_ctrl.mem_read   = id_MemRead;
      id_ctrl.mem_write  = id_MemWrite;
      id_ctrl.mem_to_reg = id_MemtoReg;
      id_ctrl.alu_src    = id_ALUSrc;
      id_ctrl.alu_op     = id_ALUOp;
    end
  end

  assign stall_hit = id_valid && ex_valid
                  && ex_ctrl.mem_read
                  && (ex_rd != '0)
                  && ((ex_rd == id_rs)
                   || (ex_rd == id_rt));

  assign stall  = stall_hit;
  assign bubble = flush || stall_hit;

  // Pipeline register: reset, then bubble, then load
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      ex_valid <= 1'b0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_rd    <= '0;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_imm   <= '0;
      ex_ctrl  <= CTRL_BUBBLE;
    end else begin
      ex_valid <= id_valid;
      ex_rs    <= id_rs;
      ex_rt    <= id_rt;
      ex_rd    <= id_rd;
      ex_a     <= op_a;
      ex_b     <= op_b;
      ex_imm   <= id_imm;
      ex_ctrl  <= id_ctrl;
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall_hit
              && stall_count != 16'hFFFF) begin
      stall_count <= stall_count + 16'd1;
    end
  end

  assign ex_RegWrite = ex_ctrl.reg_write;
  assign ex_MemRead  = ex_ctrl.mem_read;
  assign ex_MemWrite = ex_ctrl.mem_write;
  assign ex_MemtoReg = ex_ctrl.mem_to_reg;
  assign ex_ALUSrc   = ex_ctrl.alu_src;
  assign ex_ALUOp    = ex_ctrl.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: load, bypass,
// load-use stall, flush, reset and saturation.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [2:0]  id_rs, id_rt, id_rd;
  logic [15:0] id_imm;
  logic        id_RegWrite, id_MemRead;
  logic        id_MemWrite, id_MemtoReg;
  logic        id_ALUSrc;
  logic [2:0]  id_ALUOp;
  logic [15:0] rd1, rd2;
  logic        wb_RegWrite;
  logic [2:0]  wb_write_reg;
  logic [15:0] wb_write_data;
  logic        flush;
  logic        stall;
  logic        ex_valid;
  logic [2:0]  ex_rs, ex_rt, ex_rd;
  logic [15:0] ex_a, ex_b, ex_imm;
  logic        ex_RegWrite, ex_MemRead;
  logic        ex_MemWrite, ex_MemtoReg;
  logic        ex_ALUSrc;
  logic [2:0]  ex_ALUOp;
  logic [15:0] stall_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk                 (clk),
    .rst                 (rst),
    .id_valid            (id_valid),
    .id_rs               (id_rs),
    .id_rt               (id_rt),
    .id_rd               (id_rd),
    .id_imm              (id_imm),
    .id_RegWrite         (id_RegWrite),
    .id_MemRead          (id_MemRead),
    .id_MemWrite         (id_MemWrite),
    .id_MemtoReg         (id_MemtoReg),
    .id_ALUSrc           (id_ALUSrc),
    .id_ALUOp            (id_ALUOp),
    .regfile_read_data_1 (rd1),
    .regfile_read_data_2 (rd2),
    .wb_RegWrite         (wb_RegWrite),
    .wb_write_reg        (wb_write_reg),
    .wb_write_data       (wb_write_data),
    .flush               (flush),
    .stall               (stall),
    .ex_valid            (ex_valid),
    .ex_rs               (ex_rs),
    .ex_rt               (ex_rt),
    .ex_rd               (ex_rd),
    .ex_a                (ex_a),
    .ex_b                (ex_b),
    .ex_imm              (ex_imm),
    .ex_RegWrite         (ex_RegWrite),
    .ex_MemRead          (ex_MemRead),
    .ex_MemWrite         (ex_MemWrite),
    .ex_MemtoReg         (ex_MemtoReg),
    .ex_ALUSrc           (ex_ALUSrc),
    .ex_ALUOp            (ex_ALUOp),
    .stall_count         (stall_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic id_clear();
    id_valid    = 1'b0;
    id_rs       = '0;
    id_rt       = '0;
    id_rd       = '0;
    id_imm      = '0;
    id_RegWrite = 1'b0;
    id_MemRead  = 1'b0;
    id_MemWrite = 1'b0;
    id_MemtoReg = 1'b0;
    id_ALUSrc   = 1'b0;
    id_ALUOp    = '0;
    rd1         = '0;
    rd2         = '0;
  endtask

  task automatic id_lw(input logic [2:0] rd);
    id_clear();
    id_valid    = 1'b1;
    id_rs       = 3'd1;
    id_rt       = rd;
    id_rd       = rd;
    id_imm      = 16'h0004;
    id_RegWrite = 1'b1;
    id_MemRead  = 1'b1;
    id_MemtoReg = 1'b1;
    id_ALUSrc   = 1'b1;
    id_ALUOp    = 3'd1;
  endtask

  task automatic id_add(input logic [2:0] rs,
                        input logic [2:0] rt,
                        input logic [2:0] rd);
    id_clear();
    id_valid    = 1'b1;
    id_rs       = rs;
    id_rt       = rt;
    id_rd       = rd;
    id_RegWrite = 1'b1;
    id_ALUOp    = 3'd1;
  endtask

  initial begin
    rst           = 1'b1;
    flush         = 1'b0;
    wb_RegWrite   = 1'b0;
    wb_write_reg  = '0;
    wb_write_data = '0;
    id_clear();
    step();
    step();
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_a", 32'(ex_a), 32'd0);
    chk("rst_alu", 32'(ex_ALUOp), 32'd0);
    chk("rst_cnt", 32'(stall_count), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);

    rst = 1'b0;
    id_add(3'd2, 3'd3, 3'd1);
    rd1    = 16'h0002;
    rd2    = 16'h0003;
    id_imm = 16'h1234;
    #1;
    chk("load_stall", 32'(stall), 32'd0);
    step();
    chk("load_a", 32'(ex_a), 32'h0002);
    chk("load_b", 32'(ex_b), 32'h0003);
    chk("load_valid", 32'(ex_valid), 32'd1);
    chk("load_alu", 32'(ex_ALUOp), 32'd1);
    chk("load_rw", 32'(ex_RegWrite), 32'd1);
    chk("load_imm", 32'(ex_imm), 32'h1234);
    chk("load_rs", 32'(ex_rs), 32'd2);
    chk("load_stall2", 32'(stall), 32'd0);

    id_add(3'd5, 3'd6, 3'd7);
    rd1           = 16'h0005;
    rd2           = 16'h0066;
    wb_RegWrite   = 1'b1;
    wb_write_reg  = 3'd5;
    wb_write_data = 16'hBEEF;
    step();
    chk("byp_a", 32'(ex_a), 32'hBEEF);
    chk("byp_b", 32'(ex_b), 32'h0066);

    id_add(3'd0, 3'd0, 3'd7);
    rd1           = 16'h7777;
    rd2           = 16'h8888;
    wb_write_reg  = 3'd0;
    wb_write_data = 16'h1111;
    step();
    chk("r0_a", 32'(ex_a), 32'h0000);
    chk("r0_b", 32'(ex_b), 32'h0000);
    wb_RegWrite   = 1'b0;
    wb_write_data = '0;

    id_lw(3'd4);
    step();
    chk("lw_mr", 32'(ex_MemRead), 32'd1);
    chk("lw_cnt0", 32'(stall_count), 32'd0);
    id_add(3'd2, 3'd4, 3'd5);
    #1;
    chk("lu_stall", 32'(stall), 32'd1);
    step();
    chk("lu_bub_valid", 32'(ex_valid), 32'd0);
    chk("lu_bub_rw", 32'(ex_RegWrite), 32'd0);
    chk("lu_bub_mr", 32'(ex_MemRead), 32'd0);
    chk("lu_cnt", 32'(stall_count), 32'd1);
    chk("lu_stall_off", 32'(stall), 32'd0);
    step();
    chk("lu_after_valid", 32'(ex_valid), 32'd1);
    chk("lu_after_rd", 32'(ex_rd), 32'd5);
    chk("lu_after_cnt", 32'(stall_count), 32'd1);

    id_lw(3'd0);
    step();
    id_add(3'd0, 3'd0, 3'd5);
    #1;
    chk("rd0_stall", 32'(stall), 32'd0);
    step();
    chk("rd0_cnt", 32'(stall_count), 32'd1);
    chk("rd0_valid", 32'(ex_valid), 32'd1);

    id_add(3'd2, 3'd3, 3'd6);
    id_ALUOp = 3'd2;
    rd1      = 16'h00AA;
    flush    = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_valid", 32'(ex_valid), 32'd0);
    chk("fl_rw", 32'(ex_RegWrite), 32'd0);
    chk("fl_alu", 32'(ex_ALUOp), 32'd0);
    chk("fl_a", 32'(ex_a), 32'd0);
    chk("fl_cnt", 32'(stall_count), 32'd1);

    id_lw(3'd4);
    step();
    id_add(3'd4, 3'd1, 3'd2);
    flush = 1'b1;
    #1;
    chk("fs_stall", 32'(stall), 32'd1);
    step();
    flush = 1'b0;
    chk("fs_valid", 32'(ex_valid), 32'd0);
    chk("fs_cnt", 32'(stall_count), 32'd2);

    id_lw(3'd3);
    step();
    id_add(3'd3, 3'd1, 3'd2);
    #1;
    chk("rs_stall_on", 32'(stall), 32'd1);
    rst = 1'b1;
    step();
    chk("rs_valid", 32'(ex_valid), 32'd0);
    chk("rs_mr", 32'(ex_MemRead), 32'd0);
    chk("rs_rd", 32'(ex_rd), 32'd0);
    chk("rs_a", 32'(ex_a), 32'd0);
    chk("rs_cnt", 32'(stall_count), 32'd0);
    chk("rs_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    id_clear();
    step();

    force dut.stall_hit = 1'b1;
    for (int i = 0; i < 65534; i++) step();
    chk("sat_pre", 32'(stall_count), 32'hFFFE);
    for (int i = 0; i < 6; i++) step();
    chk("sat_cnt", 32'(stall_count), 32'hFFFF);
    release dut.stall_hit;
    id_lw(3'd4);
    step();
    id_add(3'd4, 3'd4, 3'd1);
    #1;
    chk("sat_stall", 32'(stall), 32'd1);
    step();
    chk("sat_hold", 32'(stall_count), 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
